// File: rtl/io_hub_pkg.sv
// Shared constants and width helpers for the io_hub UART receive path.
// Widths derived here size the byte index and the inter-byte gap timer.
package io_hub_pkg;

  localparam int UART_BYTE_W        = 8;
  localparam int DEF_WORD_BYTES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  // Flags that leave the block as single-cycle registered pulses.
  typedef struct packed {
    logic frame_drop;
    logic overrun;
  } rx_flags_t;

  // Ceiling log2, never below 1 so degenerate parameters still give a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Byte-in / word-out bundle between the UART receiver, the word assembler and its consumer.
// slave is the assembler's view; master is the view of whatever drives bytes and consumes words.
interface uart_word_rx_if
  import io_hub_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES
) ();

  localparam int IDX_W  = clog2_min1(WORD_BYTES);
  localparam int WORD_W = UART_BYTE_W * WORD_BYTES;

  logic                   byte_valid;
  logic [UART_BYTE_W-1:0] byte_data;
  logic                   byte_error;
  logic [WORD_W-1:0]      word_data;
  logic                   word_valid;
  logic                   word_ready;
  logic [IDX_W-1:0]       byte_idx;
  logic                   busy;
  logic                   frame_drop;
  logic                   overrun;

  modport slave (
    input  byte_valid, byte_data, byte_error, word_ready,
    output word_data, word_valid, byte_idx, busy, frame_drop, overrun
  );

  modport master (
    output byte_valid, byte_data, byte_error, word_ready,
    input  word_data, word_valid, byte_idx, busy, frame_drop, overrun
  );

endinterface

// File: rtl/rx_gap_timer.sv
// Counts idle cycles between bytes of a partial word and flags expiry on the terminal count.
// With TIMEOUT_CYCLES=0 the counter is not built and expire is tied low.
module rx_gap_timer
  import io_hub_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int             CNT_W = clog2_min1(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             hit;

      // clear outranks expiry so a byte landing on the terminal cycle is never dropped
      always_comb begin
        hit     = enable && !clear && (count_q == TERM);
        count_d = count_q;
        if (clear || hit) begin
          count_d = '0;
        end else if (enable) begin
          count_d = count_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expire = hit;
    end else begin : g_off
      logic unused_in;
      assign unused_in = &{1'b0, clk, rst_n, clear, enable};
      assign expire    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_word_rx.sv
// Assembles WORD_BYTES received bytes into one word behind a single output register.
// Partial words are discarded on framing error or gap timeout; a full output register causes overrun.
module uart_word_rx
  import io_hub_pkg::*;
#(
  parameter int WORD_BYTES     = DEF_WORD_BYTES,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_rx_if.slave  bus
);

  localparam int               IDX_W    = clog2_min1(WORD_BYTES);
  localparam int               WORD_W   = UART_BYTE_W * WORD_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [WORD_W-1:0] asm_q,        asm_d;
  logic [WORD_W-1:0] word_data_q,  word_data_d;
  logic              word_valid_q, word_valid_d;
  rx_flags_t         flags_q,      flags_d;

  logic              byte_accept;
  logic              word_done;
  logic              timer_clear;
  logic              timer_expire;
  logic [WORD_W-1:0] asm_next;

  assign byte_accept = bus.byte_valid & ~bus.byte_error;
  assign timer_clear = byte_accept | bus.byte_error | (idx_q == '0);

  rx_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (idx_q != '0),
    .expire (timer_expire)
  );

  // Lane i receives the byte whose arrival index maps onto it for the chosen byte order.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx_q == (BIG_ENDIAN ? IDX_W'(WORD_BYTES - 1 - i) : IDX_W'(i))) begin
        asm_next[i*UART_BYTE_W +: UART_BYTE_W] = bus.byte_data;
      end
    end
  end

  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_done    = 1'b0;
    flags_d      = '0;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;

    if (bus.byte_error) begin
      idx_d              = '0;
      asm_d              = '0;
      flags_d.frame_drop = 1'b1;
    end else if (byte_accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d     = '0;
        asm_d     = '0;
        word_done = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        asm_d = asm_next;
      end
    end else if (timer_expire) begin
      idx_d              = '0;
      asm_d              = '0;
      flags_d.frame_drop = 1'b1;
    end

    if (word_valid_q && bus.word_ready) begin
      word_valid_d = 1'b0;
    end

    // A slot freed by this cycle's handshake can take the new word directly.
    if (word_done) begin
      if (!word_valid_q || bus.word_ready) begin
        word_data_d  = asm_next;
        word_valid_d = 1'b1;
      end else begin
        flags_d.overrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      asm_q        <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.word_data  = word_data_q;
  assign bus.word_valid = word_valid_q;
  assign bus.byte_idx   = idx_q;
  assign bus.busy       = (idx_q != '0);
  assign bus.frame_drop = flags_q.frame_drop;
  assign bus.overrun    = flags_q.overrun;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed scoreboard bench: dut_a is little-endian with a 16-cycle gap timeout,
// dut_b is big-endian with the timeout disabled.
module tb_uart_word_rx;

  logic clk;
  logic rst_n;

  uart_word_rx_if #(.WORD_BYTES(4)) ifa ();
  uart_word_rx_if #(.WORD_BYTES(4)) ifb ();

  uart_word_rx #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  uart_word_rx #(.WORD_BYTES(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int drop_a = 0, ovr_a = 0, drop_b = 0, ovr_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor A: pop expected words on handshake, check hold stability, count pulses.
  logic        hold_a = 1'b0;
  logic [31:0] hold_data_a;
  logic [31:0] exp_a;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ifa.word_valid && ifa.word_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_word: got %0h, want none", ifa.word_data);
        end else begin
          exp_a = qa.pop_front();
          chk("a_word", {32'h0, ifa.word_data}, {32'h0, exp_a});
        end
      end
      if (hold_a) begin
        chk("a_hold_valid", {63'h0, ifa.word_valid}, 64'h1);
        chk("a_hold_data", {32'h0, ifa.word_data}, {32'h0, hold_data_a});
      end
      if (ifa.frame_drop) drop_a++;
      if (ifa.overrun) ovr_a++;
    end
    hold_a      = rst_n && ifa.word_valid && !ifa.word_ready;
    hold_data_a = ifa.word_data;
  end

  logic [31:0] exp_b;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ifb.word_valid && ifb.word_ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_word: got %0h, want none", ifb.word_data);
        end else begin
          exp_b = qb.pop_front();
          chk("b_word", {32'h0, ifb.word_data}, {32'h0, exp_b});
        end
      end
      if (ifb.frame_drop) drop_b++;
      if (ifb.overrun) ovr_b++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    ifa.byte_valid = 1'b1;
    ifa.byte_data  = d;
    tick(1);
    ifa.byte_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    ifb.byte_valid = 1'b1;
    ifb.byte_data  = d;
    tick(1);
    ifb.byte_valid = 1'b0;
  endtask

  task automatic err_a();
    ifa.byte_error = 1'b1;
    ifa.byte_valid = 1'b1;
    ifa.byte_data  = 8'hCC;
    tick(1);
    ifa.byte_error = 1'b0;
    ifa.byte_valid = 1'b0;
  endtask

  logic [7:0] seq4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int first_drop;

  initial begin
    rst_n = 1'b0;
    ifa.byte_valid = 1'b0; ifa.byte_data = '0; ifa.byte_error = 1'b0; ifa.word_ready = 1'b0;
    ifb.byte_valid = 1'b0; ifb.byte_data = '0; ifb.byte_error = 1'b0; ifb.word_ready = 1'b0;
    tick(3);
    chk("rst_a_valid", {63'h0, ifa.word_valid}, 64'h0);
    chk("rst_a_data", {32'h0, ifa.word_data}, 64'h0);
    chk("rst_a_idx", {62'h0, ifa.byte_idx}, 64'h0);
    chk("rst_a_busy", {63'h0, ifa.busy}, 64'h0);
    chk("rst_a_flags", {62'h0, ifa.frame_drop, ifa.overrun}, 64'h0);
    chk("rst_b_valid", {63'h0, ifb.word_valid}, 64'h0);
    rst_n = 1'b1;
    tick(1);

    // Little-endian word, consumer ready.
    ifa.word_ready = 1'b1;
    qa.push_back(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      send_a(seq4[i]);
      chk("a_le_idx", {62'h0, ifa.byte_idx}, (i == 3) ? 64'h0 : 64'(i + 1));
    end
    chk("a_le_valid_n1", {63'h0, ifa.word_valid}, 64'h1);
    chk("a_le_busy", {63'h0, ifa.busy}, 64'h0);
    tick(1);
    chk("a_le_valid_drop", {63'h0, ifa.word_valid}, 64'h0);

    // Big-endian word on dut_b.
    ifb.word_ready = 1'b1;
    qb.push_back(32'h11223344);
    for (int i = 0; i < 4; i++) begin
      send_b(seq4[i]);
      chk("b_be_idx", {62'h0, ifb.byte_idx}, (i == 3) ? 64'h0 : 64'(i + 1));
    end
    chk("b_be_valid", {63'h0, ifb.word_valid}, 64'h1);
    tick(2);

    // Stalled consumer: second word is lost with one overrun pulse.
    ifa.word_ready = 1'b0;
    qa.push_back(32'h04030201);
    for (int i = 1; i <= 8; i++) send_a(8'(i));
    chk("a_ovr_pulse", {63'h0, ifa.overrun}, 64'h1);
    chk("a_ovr_hold", {32'h0, ifa.word_data}, 64'h04030201);
    tick(1);
    chk("a_ovr_width", {63'h0, ifa.overrun}, 64'h0);
    ifa.word_ready = 1'b1;
    tick(1);
    chk("a_ovr_drain", {63'h0, ifa.word_valid}, 64'h0);

    // Framing error mid-word, then an error while idle.
    send_a(8'hAA);
    send_a(8'hBB);
    err_a();
    chk("a_err_drop", {63'h0, ifa.frame_drop}, 64'h1);
    chk("a_err_idx", {62'h0, ifa.byte_idx}, 64'h0);
    tick(1);
    chk("a_err_width", {63'h0, ifa.frame_drop}, 64'h0);
    err_a();
    chk("a_err_idle_drop", {63'h0, ifa.frame_drop}, 64'h1);
    qa.push_back(32'h04030201);
    for (int i = 1; i <= 4; i++) send_a(8'(i));
    tick(1);

    // Gap timeout: drop appears 16 cycles after the lone byte is accepted.
    send_a(8'h55);
    first_drop = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (ifa.frame_drop && first_drop == 0) first_drop = k;
    end
    chk("a_tmo_cycle", 64'(first_drop), 64'd16);
    chk("a_tmo_idx", {62'h0, ifa.byte_idx}, 64'h0);
    qa.push_back(32'h04030201);
    for (int i = 1; i <= 4; i++) send_a(8'(i));
    tick(1);

    // Byte on the terminal timer cycle wins over the timeout.
    qa.push_back(32'h88776655);
    send_a(8'h55);
    tick(15);
    send_a(8'h66);
    chk("a_tmo_edge_idx", {62'h0, ifa.byte_idx}, 64'h2);
    chk("a_tmo_edge_nodrop", {63'h0, ifa.frame_drop}, 64'h0);
    send_a(8'h77);
    send_a(8'h88);
    tick(1);

    // Final byte lands on the same edge that consumes the previous word.
    ifa.word_ready = 1'b0;
    qa.push_back(32'hD4D3D2D1);
    send_a(8'hD1); send_a(8'hD2); send_a(8'hD3); send_a(8'hD4);
    send_a(8'hE1); send_a(8'hE2); send_a(8'hE3);
    ifa.word_ready = 1'b1;
    qa.push_back(32'hE4E3E2E1);
    send_a(8'hE4);
    chk("a_b2b_valid", {63'h0, ifa.word_valid}, 64'h1);
    chk("a_b2b_data", {32'h0, ifa.word_data}, 64'hE4E3E2E1);
    chk("a_b2b_noovr", {63'h0, ifa.overrun}, 64'h0);
    tick(1);
    chk("a_b2b_drain", {63'h0, ifa.word_valid}, 64'h0);

    // Reset while a word is held and another is partly assembled.
    ifa.word_ready = 1'b0;
    send_a(8'hF1); send_a(8'hF2); send_a(8'hF3); send_a(8'hF4);
    send_a(8'h01); send_a(8'h02);
    chk("a_pre_rst_idx", {62'h0, ifa.byte_idx}, 64'h2);
    rst_n = 1'b0;
    tick(1);
    chk("a_rst_idx", {62'h0, ifa.byte_idx}, 64'h0);
    chk("a_rst_valid", {63'h0, ifa.word_valid}, 64'h0);
    chk("a_rst_data", {32'h0, ifa.word_data}, 64'h0);
    rst_n = 1'b1;
    ifa.word_ready = 1'b1;
    tick(3);

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("a_drop_count", 64'(drop_a), 64'd3);
    chk("a_ovr_count", 64'(ovr_a), 64'd1);
    chk("b_drop_count", 64'(drop_b), 64'd0);
    chk("b_ovr_count", 64'(ovr_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Parametrised byte-to-word assembler placed directly behind the UART receiver in the io_hub. Collects WORD_BYTES consecutive received bytes into one word with selectable byte order and presents it on a valid/ready interface through a one-word output register. Discards partial words on receive error or inter-byte timeout and flags output overrun, so a stalled consumer or a broken serial stream never yields a mis-aligned word.

## Interface
- WORD_BYTES, 4, bytes per assembled word (≥1)
- BIG_ENDIAN, 0, 0: first byte received lands in bits [7:0]; 1: first byte lands in the top byte
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one word; 0 disables the timeout
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- byte_valid  in  1  one-cycle pulse, byte_data holds a received byte
- byte_data  in  8  received byte
- byte_error  in  1  one-cycle pulse, UART framing error
- word_data  out  8*WORD_BYTES  assembled word, held stable while word_valid=1
- word_valid  out  1  output register holds an unconsumed word
- word_ready  in  1  consumer accepts word when word_valid & word_ready
- byte_idx  out  clog2(WORD_BYTES) (min 1)  number of bytes of the partial word collected so far
- busy  out  1  byte_idx != 0
- frame_drop  out  1  one-cycle pulse: partial word discarded (error or timeout)
- overrun  out  1  one-cycle pulse: completed word lost because output register was full

## Operation
- Reset (rst_n=0 at clk edge): byte_idx=0, assembly register=0, word_data=0, word_valid=0, frame_drop=0, overrun=0, timer=0.
- Byte accept: byte_valid=1 and byte_error=0 → byte written into lane byte_idx (LE: bits [8*idx+7:8*idx]; BE: bits [8*(WORD_BYTES-1-idx)+7 : 8*(WORD_BYTES-1-idx)]); byte_idx increments; timer cleared.
- Completion: byte accepted with byte_idx=WORD_BYTES-1 → byte_idx wraps to 0; completed word (including this byte) goes to output register if it is empty or being consumed this cycle; otherwise word dropped, old word kept, overrun pulses.
- Output handshake: word_valid clears on word_valid & word_ready unless a new word loads the same cycle (then word_valid stays 1, word_data updates, no overrun).
- Error: byte_error=1 → byte_idx=0, assembly register cleared, frame_drop pulses (also when byte_idx was 0); byte_valid in the same cycle is ignored. Output register unaffected.
- Timeout (TIMEOUT_CYCLES>0): timer counts every cycle while busy and no byte accepted; on reaching TIMEOUT_CYCLES-1 → byte_idx=0, assembly cleared, frame_drop pulses, timer=0. Timer held at 0 while idle.
- Timeout and byte accept in the same cycle: byte wins; no drop.
- WORD_BYTES=1: every accepted byte completes a word; timeout never fires.

## Timing
- Latency: final byte_valid at cycle N → word_valid=1, word_data valid at N+1.
- Throughput: one word per WORD_BYTES accepted bytes; back-to-back byte_valid every cycle supported.
- frame_drop/overrun registered, asserted the cycle after the causing event, width exactly one cycle.
- word_data and word_valid must not change while word_valid=1 and word_ready=0, except on reset.
- byte_idx/busy update the cycle after the accepting edge.

## Structure
- Package io_hub_pkg: UART_BYTE_W=8, default WORD_BYTES/TIMEOUT_CYCLES, clog2 helper for idx/timer width.
- Sub-module rx_gap_timer: clear/enable/expire counter, width clog2(TIMEOUT_CYCLES), tied off when TIMEOUT_CYCLES=0.
- Top: lane-select write into assembly register, byte_idx counter, output register with handshake, pulse flags.

## Test plan
- LE, WORD_BYTES=4: bytes 0x11,0x22,0x33,0x44, word_ready=1 → word_data=0x44332211, word_valid high one cycle, cycle after last byte.
- BIG_ENDIAN=1: same bytes → word_data=0x11223344; byte_idx sequence 1,2,3,0.
- word_ready=0, send 8 bytes 0x01..0x08 → word_data holds 0x04030201, overrun pulses once after byte 0x08; raise ready → 0x04030201 accepted, word_valid drops.
- Bytes 0xAA,0xBB then byte_error, then 0x01..0x04 → frame_drop one pulse, output 0x04030201 only.
- TIMEOUT_CYCLES=16: byte 0x55, idle 20 cycles, then 0x01..0x04 → frame_drop 16 cycles after 0x55 accept, output 0x04030201; byte at cycle 15 of gap → no drop.
- Final byte arrives same cycle word_ready accepts previous word → word_valid stays 1, new word shown, no overrun; rst_n=0 mid-word → byte_idx=0, word_valid=0 next cycle.
